// File: rtl/ads1675_pkg.sv
// Shared types and header layout for the ADS1675 frame packer.
package ads1675_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR_SYNC,
    HDR_INFO,
    DATA
  } state_t;

  localparam logic [31:0] SYNC_WORD_DEFAULT = 32'hA5A5_1675;

  localparam int SEQ_MSB = 31;
  localparam int SEQ_LSB = 16;
  localparam int CNT_MSB = 15;
  localparam int CNT_LSB = 0;

  function automatic logic [31:0] info_word(input logic [15:0] seq, input logic [15:0] cnt);
    logic [31:0] w;
    w = '0;
    w[SEQ_MSB:SEQ_LSB] = seq;
    w[CNT_MSB:CNT_LSB] = cnt;
    return w;
  endfunction

endpackage

// File: rtl/ads1675_sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered full/empty flags.
module ads1675_sync_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   wr_ptr_n;
  logic [AW:0]   rd_ptr_n;
  logic          do_wr;
  logic          do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_comb begin
    wr_ptr_n = wr_ptr + {{AW{1'b0}}, do_wr};
    rd_ptr_n = rd_ptr + {{AW{1'b0}}, do_rd};
  end

  // NOTE: storage has no reset; only the pointers and flags define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      empty  <= (wr_ptr_n == rd_ptr_n);
      full   <= (wr_ptr_n[AW] != rd_ptr_n[AW]) &&
                (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);
    end
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ads1675_frame_packer.sv
// Buffers ADC samples and emits framed AXI-Stream: sync word, info word, N samples.
module ads1675_frame_packer
  import ads1675_pkg::*;
#(
  parameter int          DW                = 32,
  parameter int          SAMPLES_PER_FRAME = 64,
  parameter int          FIFO_DEPTH        = 16,
  parameter logic [31:0] SYNC_WORD         = SYNC_WORD_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] s_axis_tdata,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  input  logic          s_axis_tlast,
  output logic [DW-1:0] m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic          m_axis_tlast,
  output logic [15:0]   seq_num,
  output logic [15:0]   overflow_cnt
);

  localparam logic [15:0] FRAME_LEN = 16'(SAMPLES_PER_FRAME);
  localparam logic [15:0] LAST_IDX  = 16'(SAMPLES_PER_FRAME - 1);

  state_t        state;
  logic [15:0]   sample_idx;
  logic          hdr_valid;
  logic [DW-1:0] hdr_data;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_wr_en;
  logic          fifo_rd_en;
  logic          handshake;
  logic          in_data;

  // Per-sample tlast from the source carries no frame meaning here.
  logic unused_ok;
  assign unused_ok = s_axis_tlast;

  assign s_axis_tready = !fifo_full;
  assign fifo_wr_en    = s_axis_tvalid && s_axis_tready;

  ads1675_sync_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr_en),
    .wr_data (s_axis_tdata),
    .rd_en   (fifo_rd_en),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Headers come from registers; samples stream straight from the FIFO head.
  assign in_data       = (state == DATA);
  assign m_axis_tvalid = in_data ? !fifo_empty : hdr_valid;
  assign m_axis_tdata  = in_data ? fifo_rd_data : hdr_data;
  assign m_axis_tlast  = in_data && (sample_idx == LAST_IDX);
  assign handshake     = m_axis_tvalid && m_axis_tready;
  assign fifo_rd_en    = in_data && handshake;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hdr_valid  <= 1'b0;
      hdr_data   <= '0;
      sample_idx <= '0;
      seq_num    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en && !fifo_empty) begin
            state     <= HDR_SYNC;
            hdr_valid <= 1'b1;
            hdr_data  <= DW'(SYNC_WORD);
          end
        end
        HDR_SYNC: begin
          if (m_axis_tready) begin
            state    <= HDR_INFO;
            hdr_data <= DW'(info_word(seq_num, FRAME_LEN));
          end
        end
        HDR_INFO: begin
          if (m_axis_tready) begin
            state     <= DATA;
            hdr_valid <= 1'b0;
            hdr_data  <= '0;
          end
        end
        DATA: begin
          if (handshake) begin
            if (m_axis_tlast) begin
              sample_idx <= '0;
              seq_num    <= seq_num + 16'd1;
              state      <= IDLE;
            end else begin
              sample_idx <= sample_idx + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_cnt <= '0;
    end else if (s_axis_tvalid && !s_axis_tready && (overflow_cnt != 16'hFFFF)) begin
      overflow_cnt <= overflow_cnt + 16'd1;
    end
  end

endmodule
